// File: rtl/dm_pipe.sv
// Pipelined data memory: byte/half/word loads and stores with a valid/ready handshake,
// 1..4 cycle read latency, alignment/range exceptions and a post-reset clear sweep.
module dm_pipe #(
  parameter int          DEPTH        = 3072,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        Sext,
  input  logic [31:0] A,
  input  logic [31:0] Din,
  output logic        Ready,
  output logic        RValid,
  output logic [31:0] Dout,
  output logic        Exc,
  output logic [1:0]  ExcCode
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, WAIT = 2'd2} state_t;

  state_t         state_r;
  logic [AW-1:0]  clr_idx_r;
  logic [2:0]     cnt_r;
  logic [31:0]    load_data_r;
  logic [31:0]    mem [DEPTH];

  logic [32:0]    off_s;
  logic           in_range_s;
  logic [AW-1:0]  widx_s;
  logic [31:0]    rd_word_s;
  logic [31:0]    merged_s;
  logic [31:0]    ext_s;
  logic [1:0]     code_s;
  logic           accept_s;
  logic           mem_we_s;
  logic [AW-1:0]  mem_waddr_s;
  logic [31:0]    mem_wdata_s;
  logic           unused_s;

  function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] din,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      2'b00:   w = din;
      2'b01:   w[{lane, 3'b000} +: 8] = din[7:0];
      2'b10:   w[{lane[1], 4'b0000} +: 16] = din[15:0];
      default: w = old_word;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = word;
      2'b01:   r = sext ? {{24{b[7]}}, b} : {24'h00_0000, b};
      2'b10:   r = sext ? {{16{h[15]}}, h} : {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // A 33-bit subtract gives the below-base borrow in bit 32 without a constant compare.
  assign off_s      = {1'b0, A} - {1'b0, BASE_ADDR};
  assign in_range_s = !off_s[32] && ({2'b00, off_s[31:2]} < 32'(DEPTH));
  assign widx_s     = off_s[AW+1:2];
  assign rd_word_s  = mem[widx_s];
  assign merged_s   = store_merge(rd_word_s, Din, Size, A[1:0]);
  assign ext_s      = load_extract(rd_word_s, Size, A[1:0], Sext);
  assign accept_s   = (state_r == IDLE) && Req;
  assign unused_s   = ^{PC, off_s[1:0]};

  // Exception classification in priority order; 2'b00 means the request is legal.
  always_comb begin
    code_s = 2'b00;
    if ((Size == 2'b11) || !in_range_s) begin
      code_s = 2'b11;
    end else if (((Size == 2'b00) && (A[1:0] != 2'b00)) || ((Size == 2'b10) && A[0])) begin
      code_s = We ? 2'b10 : 2'b01;
    end else begin
      code_s = 2'b00;
    end
  end

  // Single write port shared by the clear sweep and accepted stores.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_idx_r;
    mem_wdata_s = 32'h0000_0000;
    if (Reset) begin
      mem_we_s = 1'b0;
    end else if (state_r == CLEAR) begin
      mem_we_s = 1'b1;
    end else if (accept_s && We && (code_s == 2'b00)) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = widx_s;
      mem_wdata_s = merged_s;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // RAM array write.
  always_ff @(posedge Clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= CLEAR;
      clr_idx_r   <= '0;
      cnt_r       <= 3'd0;
      load_data_r <= 32'h0000_0000;
      Ready       <= 1'b0;
      RValid      <= 1'b0;
      Dout        <= 32'h0000_0000;
      Exc         <= 1'b0;
      ExcCode     <= 2'b00;
    end else begin
      RValid <= 1'b0;
      Exc    <= 1'b0;
      case (state_r)
        CLEAR: begin
          clr_idx_r <= clr_idx_r + 1'b1;
          if (clr_idx_r == AW'(DEPTH - 1)) begin
            clr_idx_r <= '0;
            state_r   <= IDLE;
            Ready     <= 1'b1;
          end
        end
        IDLE: begin
          if (accept_s) begin
            if (code_s != 2'b00) begin
              Exc     <= 1'b1;
              ExcCode <= code_s;
            end else if (!We) begin
              if (READ_LATENCY <= 1) begin
                Dout   <= ext_s;
                RValid <= 1'b1;
              end else begin
                load_data_r <= ext_s;
                cnt_r       <= 3'(READ_LATENCY - 1);
                state_r     <= WAIT;
                Ready       <= 1'b0;
              end
            end
          end
        end
        WAIT: begin
          if (cnt_r == 3'd1) begin
            Dout    <= load_data_r;
            RValid  <= 1'b1;
            state_r <= IDLE;
            Ready   <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          state_r   <= CLEAR;
          clr_idx_r <= '0;
          Ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_pipe.sv
// Bench for dm_pipe (DEPTH=16, READ_LATENCY=3): directed table, latency/abort sequences,
// and random requests checked against a byte-array reference model.
module tb_dm_pipe;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        Clk = 1'b0, Reset = 1'b1, Req = 1'b0, We = 1'b0, Sext = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] PC = 32'h0, A = 32'h0, Din = 32'h0;
  logic        Ready, RValid, Exc;
  logic [31:0] Dout;
  logic [1:0]  ExcCode;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mbytes [4*DEPTH];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] a;
    logic [31:0] din;
    logic [1:0]  code;
    logic [31:0] dout;
  } vec_t;
  vec_t tbl [17];

  always #5 Clk = ~Clk;

  dm_pipe #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .Req(Req), .We(We), .Size(Size), .Sext(Sext),
    .A(A), .Din(Din), .Ready(Ready), .RValid(RValid), .Dout(Dout), .Exc(Exc), .ExcCode(ExcCode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [1:0] model_code(input logic we, input logic [1:0] size, input logic [31:0] a);
    longint unsigned off;
    if (size == 2'd3 || a < BASE) return 2'd3;
    off = longint'(a) - longint'(BASE);
    if (off / 4 >= DEPTH) return 2'd3;
    if ((size == 2'd0 && off % 4 != 0) || (size == 2'd2 && off % 2 != 0)) return we ? 2'd2 : 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sext, input logic [31:0] a);
    longint v = 0;
    int n = nbytes(size);
    int off = int'(a - BASE);
    for (int i = 0; i < n; i++) v += longint'(mbytes[off + i]) << (8 * i);
    if (sext && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] din);
    int off = int'(a - BASE);
    for (int i = 0; i < nbytes(size); i++) mbytes[off + i] = din[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4 * DEPTH; i++) mbytes[i] = 8'h00;
  endtask

  // One request: waits (bounded) for Ready, issues it, checks the response and pulse width.
  task automatic req(input logic we, input logic [1:0] size, input logic sext, input logic [31:0] a,
                     input logic [31:0] din, input logic [1:0] code, input logic [31:0] dout);
    int w = 0;
    while (Ready !== 1'b1 && w < 200) begin
      @(negedge Clk);
      w++;
    end
    if (Ready !== 1'b1) begin
      check("ready_timeout", {31'd0, Ready}, 32'd1);
      return;
    end
    Req = 1'b1; We = we; Size = size; Sext = sext; A = a; Din = din; PC = $urandom;
    @(posedge Clk); #1;
    Req = 1'b0;
    if (code != 2'd0) begin
      check("exc_pulse", {31'd0, Exc}, 32'd1);
      check("exc_code", {30'd0, ExcCode}, {30'd0, code});
      check("exc_no_rvalid", {31'd0, RValid}, 32'd0);
    end else if (we) begin
      check("store_quiet", {30'd0, RValid, Exc}, 32'd0);
      check("store_ready", {31'd0, Ready}, 32'd1);
    end else begin
      for (int c = 1; c <= LAT; c++) begin
        if (c > 1) begin
          @(posedge Clk); #1;
        end
        if (c < LAT) begin
          check("load_wait", {30'd0, RValid, Ready}, 32'd0);
        end else begin
          check("load_rvalid", {30'd0, RValid, Exc}, 32'd2);
          check("load_dout", Dout, dout);
        end
      end
    end
    @(posedge Clk); #1;
    check("pulse_end", {30'd0, RValid, Exc}, 32'd0);
    @(negedge Clk);
  endtask

  // Counts edges from reset release until Ready rises; no response may pulse meanwhile.
  task automatic measure_clear(input string tag);
    int n = 0;
    logic seen = 1'b0;
    while (n < 100) begin
      @(posedge Clk); #1;
      n++;
      if (RValid || Exc) seen = 1'b1;
      if (Ready) break;
    end
    check({tag, "_ready_cycles"}, 32'(n), 32'(DEPTH));
    check({tag, "_no_pulse"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  c;
    logic [31:0] a, e;
    logic        we, sx;
    logic [1:0]  sz;

    tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h8, 32'h1122_3344, 2'd0, 32'h0};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_00AA, 2'd0, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 2'd0, 32'h11AA_3344};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 2'd0, 32'hFFFF_FFAA};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 2'd0, 32'h0000_00AA};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h6, 32'h1234_8001, 2'd0, 32'h0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 2'd0, 32'h8001_0000};
    tbl[7]  = '{1'b0, 2'd2, 1'b1, 32'h6, 32'h0, 2'd0, 32'hFFFF_8001};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 2'd0, 32'h0000_8001};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h2, 32'h0, 2'd1, 32'h0};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h5, 32'h0000_FFFF, 2'd2, 32'h0};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 2'd3, 32'h0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 2'd3, 32'h0};
    tbl[13] = '{1'b1, 2'd3, 1'b0, 32'h8, 32'hDEAD_BEEF, 2'd3, 32'h0};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 2'd0, 32'h8001_0000};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 2'd0, 32'h11AA_3344};
    tbl[16] = '{1'b0, 2'd1, 1'b1, 32'hB, 32'h0, 2'd0, 32'h0000_0011};
    model_clear();

    // Reset state and clear sweep length.
    @(posedge Clk); @(posedge Clk); #1;
    check("rst_outputs", {Ready, RValid, Exc, ExcCode}, 32'd0);
    check("rst_dout", Dout, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    measure_clear("init");
    for (int i = 0; i < DEPTH; i++) req(1'b0, 2'd0, 1'b0, 32'(4 * i), 32'h0, 2'd0, 32'h0);

    // Directed table.
    foreach (tbl[i]) begin
      req(tbl[i].we, tbl[i].size, tbl[i].sext, tbl[i].a, tbl[i].din, tbl[i].code, tbl[i].dout);
      if (tbl[i].we && tbl[i].code == 2'd0) model_store(tbl[i].size, tbl[i].a, tbl[i].din);
    end

    // Latency window: a store held on Req while Ready is low must be ignored.
    e = model_load(2'd0, 1'b0, 32'h8);
    Req = 1'b1; We = 1'b0; Size = 2'd0; A = 32'h8;
    @(posedge Clk); #1;
    check("lat_edge_k", {30'd0, Ready, RValid}, 32'd0);
    We = 1'b1; Din = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    check("lat_edge_k1", {30'd0, Ready, RValid}, 32'd0);
    @(posedge Clk); #1;
    check("lat_edge_k2", {30'd0, Ready, RValid}, 32'd3);
    check("lat_dout", Dout, e);
    Req = 1'b0;
    @(posedge Clk); #1;
    check("lat_pulse_end", {31'd0, RValid}, 32'd0);
    @(negedge Clk);
    req(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 2'd0, e);

    // Reset abort during a pending load.
    Req = 1'b1; We = 1'b0; Size = 2'd0; A = 32'h4;
    @(posedge Clk); #1;
    Req = 1'b0;
    check("abort_accepted", {31'd0, Ready}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("abort_outputs", {Ready, RValid, Exc, ExcCode}, 32'd0);
    check("abort_dout", Dout, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    measure_clear("abort");
    check("abort_dout_after", Dout, 32'h0);
    model_clear();
    req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 2'd0, 32'h0);
    req(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 2'd0, 32'h0);

    // Random requests against the reference model.
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
      Din = $urandom;
      c = model_code(we, sz, a);
      e = (c == 2'd0 && !we) ? model_load(sz, sx, a) : 32'h0;
      req(we, sz, sx, a, Din, c, e);
      if (we && c == 2'd0) model_store(sz, a, Din);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
